// File: rtl/pi_req_queue_pkg.sv
// Shared definitions for the Pi posted-request queue: register map, size codes
// and the layout of one queued request entry.
package pi_req_queue_pkg;

  localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
  localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
  localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
  localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;

  localparam logic [1:0] SIZE_WORD = 2'b01;

  localparam int ENTRY_W   = 62;
  localparam int WDATA_LSB = 0;
  localparam int ADDR_LSB  = 32;
  localparam int SIZE_LSB  = 56;
  localparam int READ_BIT  = 58;
  localparam int FC_LSB    = 59;

  // Packed MSB-first so the field positions match the offsets above.
  typedef struct packed {
    logic [2:0]  fc;
    logic        read;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/pi_req_queue_req_fifo.sv
// Register-array FIFO of request entries with synchronous flush and an
// occupancy count that can reach DEPTH.
module req_fifo
  import pi_req_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  req_entry_t                 wdata_i,
  output req_entry_t                 head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_entry_t        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are PW bits wide, so increments wrap modulo DEPTH.
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pi_req_queue.sv
// Posted-request queue: stages Pi register writes into requests, queues them
// and hands them one at a time to the 68k bus-cycle engine.
module pi_req_queue
  import pi_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic                   SYSCLK,
  input  logic                   nRESET,
  input  logic                   PI_WR_STB,
  input  logic [2:0]             PI_A,
  input  logic [15:0]            PI_D,
  input  logic                   FLUSH,
  input  logic                   CLR_ERR,
  output logic                   REQ_VALID,
  input  logic                   REQ_READY,
  output logic [AW-1:0]          REQ_ADDR,
  output logic [1:0]             REQ_SIZE,
  output logic                   REQ_READ,
  output logic [2:0]             REQ_FC,
  output logic [31:0]            REQ_WDATA,
  input  logic                   CYC_DONE,
  input  logic                   CYC_BERR,
  input  logic [31:0]            CYC_RDATA,
  output logic [31:0]            RDATA,
  output logic                   PI_BUSY,
  output logic                   EMPTY,
  output logic                   OVERFLOW,
  output logic                   BERR_FLAG,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   addr_lo_q, addr_lo_d;
  logic          inflight_q, inflight_d;
  logic          inflight_read_q, inflight_read_d;
  logic          read_pending_q, read_pending_d;
  logic          overflow_q, overflow_d;
  logic          berr_q, berr_d;
  logic [31:0]   rdata_q, rdata_d;

  req_entry_t    head;
  req_entry_t    new_entry;
  logic [CW-1:0] count;
  logic          req_valid;
  logic          pop;
  logic          commit;
  logic          accept;
  logic          done;

  assign commit    = PI_WR_STB && (PI_A == PI_REG_ADDR_HI);
  assign req_valid = (count != '0) && !inflight_q;
  assign pop       = req_valid && REQ_READY;
  assign accept    = commit && ((count < CW'(DEPTH)) || pop) && !read_pending_q && !FLUSH;
  assign done      = CYC_DONE && inflight_q;

  assign new_entry = '{fc:    PI_D[13:11],
                       read:  PI_D[10],
                       size:  PI_D[9:8],
                       addr:  {PI_D[7:0], addr_lo_q},
                       wdata: wdata_q};

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (SYSCLK),
    .rst_ni  (nRESET),
    .push_i  (accept),
    .pop_i   (pop),
    .flush_i (FLUSH),
    .wdata_i (new_entry),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    wdata_d         = wdata_q;
    addr_lo_d       = addr_lo_q;
    inflight_d      = inflight_q;
    inflight_read_d = inflight_read_q;
    read_pending_d  = read_pending_q;
    rdata_d         = rdata_q;

    if (PI_WR_STB) begin
      case (PI_A)
        PI_REG_DATA_LO: wdata_d[15:0]  = PI_D;
        PI_REG_DATA_HI: wdata_d[31:16] = PI_D;
        PI_REG_ADDR_LO: addr_lo_d      = PI_D;
        default: ;
      endcase
    end

    if (done) begin
      inflight_d = 1'b0;
      if (inflight_read_q) begin
        rdata_d        = CYC_RDATA;
        read_pending_d = 1'b0;
      end
    end
    if (pop) begin
      inflight_d      = 1'b1;
      inflight_read_d = head.read;
    end
    // A read that is (or is just becoming) in flight survives a flush.
    if (FLUSH && !(inflight_d && inflight_read_d)) read_pending_d = 1'b0;
    if (accept && new_entry.read) read_pending_d = 1'b1;

    overflow_d = (overflow_q && !CLR_ERR) || (commit && !accept && !FLUSH);
    berr_d     = (berr_q && !CLR_ERR) || (done && CYC_BERR);
  end

  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      wdata_q         <= '0;
      addr_lo_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_read_q <= 1'b0;
      read_pending_q  <= 1'b0;
      overflow_q      <= 1'b0;
      berr_q          <= 1'b0;
      rdata_q         <= '0;
    end else begin
      wdata_q         <= wdata_d;
      addr_lo_q       <= addr_lo_d;
      inflight_q      <= inflight_d;
      inflight_read_q <= inflight_read_d;
      read_pending_q  <= read_pending_d;
      overflow_q      <= overflow_d;
      berr_q          <= berr_d;
      rdata_q         <= rdata_d;
    end
  end

  assign REQ_VALID = req_valid;
  assign REQ_ADDR  = head.addr;
  assign REQ_SIZE  = head.size;
  assign REQ_READ  = head.read;
  assign REQ_FC    = head.fc;
  assign REQ_WDATA = head.wdata;
  assign RDATA     = rdata_q;
  assign PI_BUSY   = (count == CW'(DEPTH)) || read_pending_q;
  assign EMPTY     = (count == '0) && !inflight_q;
  assign OVERFLOW  = overflow_q;
  assign BERR_FLAG = berr_q;
  assign COUNT     = count;

endmodule

// File: tb/tb_pi_req_queue.sv
// Directed and randomized checks of pi_req_queue against a queue-based model.
module tb_pi_req_queue;

  localparam int DEPTH = 4;

  logic        SYSCLK = 1'b0;
  logic        nRESET;
  logic        PI_WR_STB = 1'b0;
  logic [2:0]  PI_A = '0;
  logic [15:0] PI_D = '0;
  logic        FLUSH = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        REQ_VALID;
  logic        REQ_READY = 1'b0;
  logic [23:0] REQ_ADDR;
  logic [1:0]  REQ_SIZE;
  logic        REQ_READ;
  logic [2:0]  REQ_FC;
  logic [31:0] REQ_WDATA;
  logic        CYC_DONE = 1'b0;
  logic        CYC_BERR = 1'b0;
  logic [31:0] CYC_RDATA = '0;
  logic [31:0] RDATA;
  logic        PI_BUSY;
  logic        EMPTY;
  logic        OVERFLOW;
  logic        BERR_FLAG;
  logic [2:0]  COUNT;

  int tests = 0;
  int fails = 0;

  pi_req_queue #(.DEPTH(DEPTH), .AW(24)) dut (
    .SYSCLK(SYSCLK), .nRESET(nRESET), .PI_WR_STB(PI_WR_STB), .PI_A(PI_A), .PI_D(PI_D),
    .FLUSH(FLUSH), .CLR_ERR(CLR_ERR), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_READ(REQ_READ), .REQ_FC(REQ_FC),
    .REQ_WDATA(REQ_WDATA), .CYC_DONE(CYC_DONE), .CYC_BERR(CYC_BERR), .CYC_RDATA(CYC_RDATA),
    .RDATA(RDATA), .PI_BUSY(PI_BUSY), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW),
    .BERR_FLAG(BERR_FLAG), .COUNT(COUNT)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_infl, m_infl_read, m_rp, m_ovf, m_berr;
  logic [31:0] m_rdata;
  logic [15:0] m_wlo, m_whi, m_alo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl = 0; m_infl_read = 0; m_rp = 0; m_ovf = 0; m_berr = 0;
    m_rdata = '0; m_wlo = '0; m_whi = '0; m_alo = '0;
  endtask

  task automatic check_all();
    bit v;
    v = (mq.size() > 0) && !m_infl;
    chk("req_valid", REQ_VALID, v);
    chk("count", COUNT, mq.size());
    chk("pi_busy", PI_BUSY, (mq.size() == DEPTH) || m_rp);
    chk("empty", EMPTY, (mq.size() == 0) && !m_infl);
    chk("overflow", OVERFLOW, m_ovf);
    chk("berr_flag", BERR_FLAG, m_berr);
    chk("rdata", RDATA, m_rdata);
    if (v) begin
      chk("req_addr", REQ_ADDR, mq[0].addr);
      chk("req_size", REQ_SIZE, mq[0].size);
      chk("req_read", REQ_READ, mq[0].read);
      chk("req_fc", REQ_FC, mq[0].fc);
      chk("req_wdata", REQ_WDATA, mq[0].wdata);
    end
  endtask

  // One clock: the model evaluates the current inputs, then the DUT is checked.
  task automatic cycle();
    bit commit, pop, acc, done, flush, clr, berr;
    logic [31:0] rd;
    m_ent_t ne;
    commit = PI_WR_STB && (PI_A == 3'd3);
    pop    = REQ_READY && (mq.size() > 0) && !m_infl;
    acc    = commit && ((mq.size() < DEPTH) || pop) && !m_rp && !FLUSH;
    done   = CYC_DONE && m_infl;
    flush  = FLUSH;
    clr    = CLR_ERR;
    berr   = CYC_BERR;
    rd     = CYC_RDATA;
    ne = '{addr: {PI_D[7:0], m_alo}, size: PI_D[9:8], read: PI_D[10],
           fc: PI_D[13:11], wdata: {m_whi, m_wlo}};
    @(posedge SYSCLK);
    #1;
    if (clr) begin m_ovf = 0; m_berr = 0; end
    if (done) begin
      m_infl = 0;
      if (m_infl_read) begin m_rdata = rd; m_rp = 0; end
      if (berr) m_berr = 1;
    end
    if (pop) begin
      m_infl_read = mq[0].read;
      void'(mq.pop_front());
      m_infl = 1;
    end
    if (flush) begin
      mq.delete();
      if (!(m_infl && m_infl_read)) m_rp = 0;
    end
    if (acc) begin
      mq.push_back(ne);
      if (ne.read) m_rp = 1;
    end
    if (commit && !acc && !flush) m_ovf = 1;
    if (PI_WR_STB) begin
      if (PI_A == 3'd0) m_wlo = PI_D;
      if (PI_A == 3'd1) m_whi = PI_D;
      if (PI_A == 3'd2) m_alo = PI_D;
    end
    PI_WR_STB = 0; FLUSH = 0; CLR_ERR = 0; CYC_DONE = 0; CYC_BERR = 0;
    check_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    PI_WR_STB = 1; PI_A = a; PI_D = d;
    cycle();
  endtask

  task automatic commit_req(input logic [23:0] addr, input logic [1:0] size,
                            input logic rd, input logic [2:0] fc, input logic [31:0] wd);
    wr(3'd0, wd[15:0]);
    wr(3'd1, wd[31:16]);
    wr(3'd2, addr[15:0]);
    wr(3'd3, {2'b00, fc, rd, size, addr[23:16]});
  endtask

  task automatic cyc_done(input logic berr, input logic [31:0] rd);
    CYC_DONE = 1; CYC_BERR = berr; CYC_RDATA = rd;
    cycle();
  endtask

  initial begin
    model_reset();
    nRESET = 1'b0;
    repeat (2) @(posedge SYSCLK);
    #1;
    nRESET = 1'b1;
    chk("reset_empty", EMPTY, 1'b1);
    chk("reset_valid", REQ_VALID, 1'b0);
    chk("reset_busy", PI_BUSY, 1'b0);
    check_all();

    // Basic write request and completion.
    REQ_READY = 1;
    wr(3'd0, 16'h1234);
    wr(3'd1, 16'hABCD);
    wr(3'd2, 16'h0010);
    wr(3'd3, 16'h0A01);
    chk("t1_valid", REQ_VALID, 1'b1);
    chk("t1_addr", REQ_ADDR, 24'h010010);
    chk("t1_size", REQ_SIZE, 2'b10);
    chk("t1_read", REQ_READ, 1'b0);
    chk("t1_fc", REQ_FC, 3'b001);
    chk("t1_wdata", REQ_WDATA, 32'hABCD1234);
    cycle();
    chk("t1_inflight_notempty", EMPTY, 1'b0);
    cyc_done(0, 32'h0);
    chk("t1_empty", EMPTY, 1'b1);

    // Fill to depth, overflow, clear, drain in order.
    REQ_READY = 0;
    for (int i = 0; i < 5; i++)
      commit_req(24'h100000 + 24'(i * 16), 2'b01, 0, 3'd5, 32'hC0DE0000 + 32'(i));
    chk("t2_count", COUNT, 3'd4);
    chk("t2_busy", PI_BUSY, 1'b1);
    chk("t2_ovf", OVERFLOW, 1'b1);
    CLR_ERR = 1;
    cycle();
    chk("t2_ovf_clr", OVERFLOW, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_addr", REQ_ADDR, 24'h100000 + 24'(i * 16));
      REQ_READY = 1;
      cycle();
      REQ_READY = 0;
      cyc_done(0, 32'h0);
    end
    chk("t2_drained", EMPTY, 1'b1);

    // Read blocks further commits until its data returns.
    commit_req(24'h00ABCD, 2'b01, 1, 3'd5, 32'h0);
    chk("t3_busy", PI_BUSY, 1'b1);
    commit_req(24'h000002, 2'b01, 0, 3'd5, 32'h1);
    chk("t3_ovf", OVERFLOW, 1'b1);
    chk("t3_count", COUNT, 3'd1);
    REQ_READY = 1;
    cycle();
    REQ_READY = 0;
    cyc_done(0, 32'hDEADBEEF);
    chk("t3_rdata", RDATA, 32'hDEADBEEF);
    chk("t3_busy_clr", PI_BUSY, 1'b0);
    CLR_ERR = 1;
    cycle();

    // Bus error is sticky until cleared.
    commit_req(24'h000100, 2'b11, 0, 3'd1, 32'h55);
    REQ_READY = 1; cycle(); REQ_READY = 0;
    cyc_done(1, 32'h0);
    chk("t4_berr", BERR_FLAG, 1'b1);
    commit_req(24'h000104, 2'b11, 0, 3'd1, 32'h66);
    REQ_READY = 1; cycle(); REQ_READY = 0;
    cyc_done(0, 32'h0);
    chk("t4_berr_sticky", BERR_FLAG, 1'b1);
    CLR_ERR = 1;
    cycle();
    chk("t4_berr_clr", BERR_FLAG, 1'b0);

    // Flush with one cycle in flight.
    commit_req(24'h000200, 2'b01, 0, 3'd2, 32'h1);
    REQ_READY = 1; cycle(); REQ_READY = 0;
    for (int i = 0; i < 3; i++) commit_req(24'h000300 + 24'(i), 2'b01, 0, 3'd2, 32'h2);
    chk("t5_count", COUNT, 3'd3);
    FLUSH = 1;
    cycle();
    chk("t5_flush_count", COUNT, 3'd0);
    chk("t5_flush_valid", REQ_VALID, 1'b0);
    chk("t5_inflight", EMPTY, 1'b0);
    cyc_done(0, 32'h0);
    chk("t5_empty", EMPTY, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    commit_req(24'h000400, 2'b01, 0, 3'd3, 32'h7);
    REQ_READY = 1; cycle(); REQ_READY = 0;
    commit_req(24'h000500, 2'b01, 0, 3'd3, 32'h8);
    commit_req(24'h000600, 2'b01, 0, 3'd3, 32'h9);
    chk("t6_count", COUNT, 3'd2);
    #2;
    nRESET = 1'b0;
    #1;
    chk("t6_rst_count", COUNT, 3'd0);
    chk("t6_rst_valid", REQ_VALID, 1'b0);
    chk("t6_rst_empty", EMPTY, 1'b1);
    chk("t6_rst_busy", PI_BUSY, 1'b0);
    model_reset();
    @(posedge SYSCLK);
    #1;
    nRESET = 1'b1;
    check_all();
    cyc_done(0, 32'h12345678);
    chk("t6_done_ignored", RDATA, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        PI_WR_STB = 1;
        PI_A = ($urandom_range(0, 9) < 4) ? 3'd3 : 3'($urandom_range(0, 7));
        PI_D = 16'($urandom);
        PI_D[10] = ($urandom_range(0, 3) == 0);
      end
      REQ_READY = 1'($urandom_range(0, 1));
      CYC_DONE  = ($urandom_range(0, 2) == 0);
      CYC_BERR  = ($urandom_range(0, 5) == 0);
      CYC_RDATA = $urandom;
      FLUSH     = ($urandom_range(0, 29) == 0);
      CLR_ERR   = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pi_req_queue.md
Name: pi_req_queue

Overview:
Posted-request queue between the Pi GPIO register interface and the 68k bus-cycle engine. It captures Pi register writes (DATA_LO/HI, ADDR_LO/HI), commits a full request on each ADDR_HI write, and buffers requests in a FIFO. It presents requests to the bus engine over a valid/ready handshake and tracks the single in-flight cycle. Writes are posted; a read blocks further requests until its data returns.

Parameters:
DEPTH, 4, number of queued request entries (power of two, >= 2)
AW, 24, address width (bits 23:0)

Ports:
SYSCLK  in  1  system clock from PLL
nRESET  in  1  asynchronous, active-low reset
PI_WR_STB  in  1  one-cycle pulse, already synchronized: Pi register write
PI_A  in  3  Pi register address
PI_D  in  16  Pi write data
FLUSH  in  1  one-cycle pulse: discard all queued, not-yet-issued entries
CLR_ERR  in  1  one-cycle pulse: clear sticky OVERFLOW and BERR_FLAG
REQ_VALID  out  1  head entry available to bus engine
REQ_READY  in  1  bus engine accepts head entry this cycle
REQ_ADDR  out  24  head address
REQ_SIZE  out  2  head size (01 word, 10/11 long)
REQ_READ  out  1  head is a read
REQ_FC  out  3  head function code
REQ_WDATA  out  32  head write data
CYC_DONE  in  1  one-cycle pulse: in-flight bus cycle terminated
CYC_BERR  in  1  qualifies CYC_DONE: cycle ended with bus error
CYC_RDATA  in  32  read data, valid with CYC_DONE
RDATA  out  32  last read result
PI_BUSY  out  1  Pi must not commit a new request
EMPTY  out  1  no queued entries and nothing in flight
OVERFLOW  out  1  sticky: a commit was rejected
BERR_FLAG  out  1  sticky: a completed cycle reported bus error
COUNT  out  clog2(DEPTH)+1  queued entries, excluding in-flight

Behaviour:
- Reset (async assert, sync release): pointers, COUNT, staging registers, RDATA, flags = 0; REQ_VALID=0; PI_BUSY=0; EMPTY=1; inflight=0; read_pending=0.
- Staging: PI_WR_STB with PI_A=0 loads wdata[15:0]; with PI_A=1 loads wdata[31:16]; with PI_A=2 loads addr[15:0]. PI_A=3 commits the entry {addr[23:16]=PI_D[7:0], size=PI_D[9:8], read=PI_D[10], fc=PI_D[13:11]} plus staged fields. Other PI_A values are ignored. Staging registers persist across commits.
- Commit is accepted iff (COUNT<DEPTH or pop in the same cycle) and read_pending=0 and FLUSH=0. Otherwise the entry is dropped and OVERFLOW is set. Accepted commit is visible on REQ_* the next cycle; commit-to-REQ_VALID latency is 1 cycle.
- An accepted read commit sets read_pending.
- Pop occurs on REQ_VALID & REQ_READY. It requires inflight=0: REQ_VALID = (COUNT>0) & ~inflight. Pop sets inflight and latches inflight_read.
- CYC_DONE clears inflight. If inflight_read, RDATA<=CYC_RDATA and read_pending clears. CYC_BERR sets BERR_FLAG. RDATA is latched even on BERR. CYC_DONE while inflight=0 is ignored.
- CYC_DONE and a pop in the same cycle are not possible (pop requires inflight=0). CYC_DONE in cycle N allows a pop in cycle N+1.
- PI_BUSY = (COUNT==DEPTH) | read_pending.
- EMPTY = (COUNT==0) & ~inflight.
- FLUSH resets rd/wr pointers and COUNT. It also clears read_pending unless the pending read is the in-flight one. The in-flight cycle completes normally. A commit in the same cycle as FLUSH is dropped, but OVERFLOW is not set.
- CLR_ERR and a setting event in the same cycle: the set wins.
- Pointers wrap modulo DEPTH. COUNT saturates logically at DEPTH via the accept rule and never wraps.
- No combinational path from REQ_READY to REQ_VALID.

Decomposition:
- Shared package holds:
  - PI_REG_DATA_LO=0, PI_REG_DATA_HI=1, PI_REG_ADDR_LO=2, PI_REG_ADDR_HI=3
  - SIZE_WORD=2'b01
  - entry field offsets, entry width = 62 bits
- Sub-module: req_fifo (DEPTH x 62 register-array FIFO with push/pop/flush, count). Top handles staging, accept rules, in-flight tracking, flags.

Test Plan:
- Write sequence A=0:1234, A=1:ABCD, A=2:0010, A=3:0x0A01, engine ready=1 -> next cycle REQ_VALID=1, REQ_ADDR=0x010010, REQ_SIZE=10, REQ_READ=0, REQ_FC=001, REQ_WDATA=0xABCD1234. Pop; after CYC_DONE, EMPTY=1.
- Five write commits with REQ_READY=0, DEPTH=4 -> COUNT=4, PI_BUSY=1, fifth dropped, OVERFLOW=1. Then CLR_ERR -> OVERFLOW=0. Drain in order with addresses intact.
- Read commit (PI_D bit10=1) -> PI_BUSY=1. Next commit rejected (OVERFLOW=1). CYC_DONE with CYC_RDATA=0xDEADBEEF -> RDATA=0xDEADBEEF, PI_BUSY=0.
- CYC_DONE with CYC_BERR=1 on a write -> BERR_FLAG=1 sticky through later good cycles. CLR_ERR clears it.
- Three queued writes, one in flight, FLUSH -> COUNT=0, REQ_VALID=0. In-flight CYC_DONE still clears inflight, EMPTY=1.
- nRESET asserted mid-flight with COUNT=2 -> all outputs at reset values immediately, no clock required. Later CYC_DONE is ignored.
